// File: rtl/crossword_pkg.sv
// Shared constants, keycodes and FSM state type for the crossword cursor logic.
package crossword_pkg;

  localparam int GRID_N       = 5;
  localparam int CELL_SIZE    = 80;
  localparam int X_ORIGIN     = 4;
  localparam int Y_ORIGIN     = 80;
  localparam int REPEAT_DELAY = 30;
  localparam int REPEAT_RATE  = 6;

  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_BKSP  = 8'h2A;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_Z     = 8'h1D;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    BACKSPACE_WRITE
  } state_t;

  function automatic logic is_letter(input logic [7:0] code);
    return (code >= KEY_A) && (code <= KEY_Z);
  endfunction

  // One cell forward/back, saturating at the grid edges (no wrap).
  function automatic logic [2:0] step_fwd(input logic [2:0] v);
    return (v == 3'(GRID_N - 1)) ? v : v + 3'd1;
  endfunction

  function automatic logic [2:0] step_back(input logic [2:0] v);
    return (v == 3'd0) ? v : v - 3'd1;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Turns the level-held keycode into discrete key events with typematic repeat.
import crossword_pkg::*;

module key_repeat #(
  parameter int REPEAT_DELAY = crossword_pkg::REPEAT_DELAY,
  parameter int REPEAT_RATE  = crossword_pkg::REPEAT_RATE
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  output logic       key_evt,
  output logic [7:0] evt_code
);

  logic [7:0] prev_key;
  logic [7:0] hold_cnt;
  logic [7:0] hold_inc;
  logic       new_evt;
  logic       rpt_evt;

  assign new_evt  = (keycode != 8'd0) && (keycode != prev_key);
  assign hold_inc = hold_cnt + 8'd1;
  // The repeat fires on the frame the count reaches the delay, so the first
  // repeat lands REPEAT_DELAY frames after the press and then every REPEAT_RATE.
  assign rpt_evt  = !new_evt && (keycode != 8'd0) && (hold_inc == 8'(REPEAT_DELAY));
  assign key_evt  = new_evt | rpt_evt;
  assign evt_code = keycode;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_key <= 8'd0;
      hold_cnt <= 8'd0;
    end else begin
      prev_key <= keycode;
      if (new_evt || keycode == 8'd0)
        hold_cnt <= 8'd0;
      else if (rpt_evt)
        hold_cnt <= 8'(REPEAT_DELAY - REPEAT_RATE);
      else
        hold_cnt <= hold_inc;
    end
  end

endmodule

// File: rtl/cursor_controller.sv
// Crossword cursor FSM: moves the highlight cell, toggles direction and issues
// single-cell letter/blank writes to the grid store with auto-advance.
import crossword_pkg::*;

module cursor_controller #(
  parameter int REPEAT_DELAY = crossword_pkg::REPEAT_DELAY,
  parameter int REPEAT_RATE  = crossword_pkg::REPEAT_RATE
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       wr_ack,
  output logic [2:0] cell_row,
  output logic [2:0] cell_col,
  output logic       dir_down,
  output logic [9:0] highlightX,
  output logic [9:0] highlightY,
  output logic       wr_req,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic [4:0] wr_data
);

  logic       key_evt;
  logic [7:0] evt_code;
  state_t     state;

  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_key_repeat (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .keycode   (keycode),
    .key_evt   (key_evt),
    .evt_code  (evt_code)
  );

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cell_row <= 3'd0;
      cell_col <= 3'd0;
      dir_down <= 1'b0;
      wr_req   <= 1'b0;
      wr_row   <= 3'd0;
      wr_col   <= 3'd0;
      wr_data  <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (key_evt) begin
            if (is_letter(evt_code)) begin
              wr_req  <= 1'b1;
              wr_row  <= cell_row;
              wr_col  <= cell_col;
              wr_data <= 5'(evt_code - 8'd3);
              state   <= WRITE;
            end else begin
              case (evt_code)
                KEY_RIGHT: cell_col <= step_fwd(cell_col);
                KEY_LEFT:  cell_col <= step_back(cell_col);
                KEY_DOWN:  cell_row <= step_fwd(cell_row);
                KEY_UP:    cell_row <= step_back(cell_row);
                KEY_SPACE: dir_down <= ~dir_down;
                KEY_BKSP: begin
                  wr_req  <= 1'b1;
                  wr_row  <= cell_row;
                  wr_col  <= cell_col;
                  wr_data <= 5'd0;
                  state   <= BACKSPACE_WRITE;
                end
                default: ;
              endcase
            end
          end
        end
        // Key events arriving while a write is outstanding are dropped,
        // including one coincident with the ack.
        WRITE: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            if (dir_down) cell_row <= step_fwd(cell_row);
            else          cell_col <= step_fwd(cell_col);
            state <= IDLE;
          end
        end
        BACKSPACE_WRITE: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            if (dir_down) cell_row <= step_back(cell_row);
            else          cell_col <= step_back(cell_col);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign highlightX = 10'(X_ORIGIN) + 10'(cell_col) * 10'(CELL_SIZE);
  assign highlightY = 10'(Y_ORIGIN) + 10'(cell_row) * 10'(CELL_SIZE);

endmodule

// File: tb/tb_cursor_controller.sv
// Scoreboard bench for cursor_controller: expected output snapshots are queued
// with each frame of stimulus and compared against the captured outputs.
module tb_cursor_controller;

  logic       frame_clk;
  logic       Reset_n;
  logic [7:0] keycode;
  logic       wr_ack;
  logic [2:0] cell_row, cell_col, wr_row, wr_col;
  logic       dir_down, wr_req;
  logic [9:0] highlightX, highlightY;
  logic [4:0] wr_data;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic       dir;
    logic       req;
    logic [2:0] wrow;
    logic [2:0] wcol;
    logic [4:0] wdata;
    logic [9:0] hx;
    logic [9:0] hy;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];
  int tests_run = 0;
  int failed    = 0;

  cursor_controller dut (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .keycode    (keycode),
    .wr_ack     (wr_ack),
    .cell_row   (cell_row),
    .cell_col   (cell_col),
    .dir_down   (dir_down),
    .highlightX (highlightX),
    .highlightY (highlightY),
    .wr_req     (wr_req),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_data    (wr_data)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  function automatic snap_t mk(input int r, input int c, input int d, input int q,
                               input int wr, input int wc, input int wd);
    snap_t s;
    s.row = 3'(r); s.col = 3'(c); s.dir = 1'(d); s.req = 1'(q);
    s.wrow = 3'(wr); s.wcol = 3'(wc); s.wdata = 5'(wd);
    s.hx = 10'(4 + c * 80);
    s.hy = 10'(80 + r * 80);
    return s;
  endfunction

  function automatic snap_t cur();
    snap_t s;
    s.row = cell_row; s.col = cell_col; s.dir = dir_down; s.req = wr_req;
    s.wrow = wr_row; s.wcol = wr_col; s.wdata = wr_data;
    s.hx = highlightX; s.hy = highlightY;
    return s;
  endfunction

  // One frame: inputs set away from the edge, outputs captured 1 time unit after it.
  task automatic step(input logic [7:0] k, input logic a, input snap_t e);
    keycode = k;
    wr_ack  = a;
    exp_q.push_back(e);
    @(posedge frame_clk);
    #1;
    obs_q.push_back(cur());
  endtask

  task automatic do_reset();
    keycode = 8'd0;
    wr_ack  = 1'b0;
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t o;
    keycode = 8'h4F;
    wr_ack  = 1'b1;
    Reset_n = 1'b0;
    #2;
    o = cur();
    tests_run++;
    if (o !== mk(0, 0, 0, 0, 0, 0, 0)) begin
      failed++;
      $display("FAIL reset_state got %p want %p", o, mk(0, 0, 0, 0, 0, 0, 0));
    end
    do_reset();
  endtask

  task automatic test_move_right();
    snap_t e, o;
    step(8'h4F, 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
    tests_run++;
    o = cur();
    if (o.hx !== 10'd84) begin
      failed++;
      $display("FAIL right_x84 got %0d want 84", o.hx);
    end
    step(8'h00, 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      step(8'h4F, 1'b0, mk(0, (i + 2 > 4) ? 4 : i + 2, 0, 0, 0, 0, 0));
      step(8'h00, 1'b0, mk(0, (i + 2 > 4) ? 4 : i + 2, 0, 0, 0, 0, 0));
    end
    tests_run++;
    o = cur();
    if (o.hx !== 10'd324) begin
      failed++;
      $display("FAIL right_clamp_x324 got %0d want 324", o.hx);
    end
    step(8'h3A, 1'b0, mk(0, 4, 0, 0, 0, 0, 0));
    step(8'h00, 1'b0, mk(0, 4, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
      if (o !== e) begin failed++; $display("FAIL move_right got %p want %p", o, e); end
    end
  endtask

  task automatic test_hold_repeat();
    snap_t e, o;
    int n;
    do_reset();
    n = 0;
    for (int f = 0; f < 45; f++) begin
      if (f == 0 || f == 30 || f == 36 || f == 42) n++;
      step(8'h51, 1'b0, mk((n > 4) ? 4 : n, 0, 0, 0, 0, 0, 0));
    end
    step(8'h00, 1'b0, mk(4, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
      if (o !== e) begin failed++; $display("FAIL hold_repeat got %p want %p", o, e); end
    end
  endtask

  task automatic test_letter_write();
    snap_t e, o;
    do_reset();
    step(8'h51, 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    step(8'h00, 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    step(8'h51, 1'b0, mk(2, 0, 0, 0, 0, 0, 0));
    step(8'h00, 1'b0, mk(2, 0, 0, 0, 0, 0, 0));
    step(8'h4F, 1'b0, mk(2, 1, 0, 0, 0, 0, 0));
    step(8'h00, 1'b0, mk(2, 1, 0, 0, 0, 0, 0));
    step(8'h0B, 1'b0, mk(2, 1, 0, 1, 2, 1, 8));
    step(8'h00, 1'b0, mk(2, 1, 0, 1, 2, 1, 8));
    step(8'h00, 1'b0, mk(2, 1, 0, 1, 2, 1, 8));
    step(8'h00, 1'b1, mk(2, 2, 0, 0, 2, 1, 8));
    step(8'h00, 1'b0, mk(2, 2, 0, 0, 2, 1, 8));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
      if (o !== e) begin failed++; $display("FAIL letter_write got %p want %p", o, e); end
    end
  endtask

  task automatic test_dir_backspace();
    snap_t e, o;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(8'h4F, 1'b0, mk(0, i, 0, 0, 0, 0, 0));
      step(8'h00, 1'b0, mk(0, i, 0, 0, 0, 0, 0));
    end
    step(8'h2C, 1'b0, mk(0, 4, 1, 0, 0, 0, 0));
    step(8'h00, 1'b0, mk(0, 4, 1, 0, 0, 0, 0));
    step(8'h04, 1'b0, mk(0, 4, 1, 1, 0, 4, 1));
    step(8'h00, 1'b1, mk(1, 4, 1, 0, 0, 4, 1));
    step(8'h2A, 1'b0, mk(1, 4, 1, 1, 1, 4, 0));
    step(8'h00, 1'b1, mk(0, 4, 1, 0, 1, 4, 0));
    step(8'h2C, 1'b0, mk(0, 4, 0, 0, 1, 4, 0));
    step(8'h00, 1'b0, mk(0, 4, 0, 0, 1, 4, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
      if (o !== e) begin failed++; $display("FAIL dir_backspace got %p want %p", o, e); end
    end
  endtask

  task automatic test_low_edge();
    snap_t e, o;
    do_reset();
    step(8'h50, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    step(8'h52, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    step(8'h2A, 1'b0, mk(0, 0, 0, 1, 0, 0, 0));
    step(8'h00, 1'b1, mk(0, 0, 0, 0, 0, 0, 0));
    step(8'h00, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
      if (o !== e) begin failed++; $display("FAIL low_edge got %p want %p", o, e); end
    end
  endtask

  task automatic test_busy_discard();
    snap_t e, o;
    do_reset();
    step(8'h05, 1'b0, mk(0, 0, 0, 1, 0, 0, 2));
    step(8'h4F, 1'b0, mk(0, 0, 0, 1, 0, 0, 2));
    step(8'h00, 1'b0, mk(0, 0, 0, 1, 0, 0, 2));
    step(8'h06, 1'b0, mk(0, 0, 0, 1, 0, 0, 2));
    step(8'h51, 1'b1, mk(0, 1, 0, 0, 0, 0, 2));
    step(8'h51, 1'b0, mk(0, 1, 0, 0, 0, 0, 2));
    step(8'h00, 1'b1, mk(0, 1, 0, 0, 0, 0, 2));
    step(8'h00, 1'b0, mk(0, 1, 0, 0, 0, 0, 2));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
      if (o !== e) begin failed++; $display("FAIL busy_discard got %p want %p", o, e); end
    end
  endtask

  task automatic test_reset_mid_write();
    snap_t e, o;
    do_reset();
    step(8'h4F, 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
    step(8'h07, 1'b0, mk(0, 1, 0, 1, 0, 1, 4));
    Reset_n = 1'b0;
    #1;
    tests_run++;
    if (wr_req !== 1'b0) begin
      failed++;
      $display("FAIL async_drop got wr_req=%0b want 0", wr_req);
    end
    step(8'h00, 1'b1, mk(0, 0, 0, 0, 0, 0, 0));
    Reset_n = 1'b1;
    step(8'h00, 1'b1, mk(0, 0, 0, 0, 0, 0, 0));
    step(8'h00, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
      if (o !== e) begin failed++; $display("FAIL reset_mid_write got %p want %p", o, e); end
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    keycode = 8'd0;
    wr_ack  = 1'b0;
    @(posedge frame_clk);
    #1;
    test_reset();
    test_move_right();
    test_hold_repeat();
    test_letter_write();
    test_dir_backspace();
    test_low_edge();
    test_busy_discard();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/cursor_controller.md
Name: cursor_controller

Overview:
- Sequences the crossword highlight cursor and letter entry from the USB keyboard keycode stream.
- Converts raw, level-held keycodes into discrete key events with typematic auto-repeat.
- Moves the cursor cell and toggles the entry direction (across/down).
- Issues single-cell write requests to the grid letter store, then auto-advances. Drives highlight pixel coordinates to the VGA colour mapper.

Parameters:
GRID_N, 5, cells per row and per column
CELL_SIZE, 80, pixel pitch of one cell
X_ORIGIN, 4, pixel X of column 0 corner
Y_ORIGIN, 80, pixel Y of row 0 corner
REPEAT_DELAY, 30, frames a key is held before the first repeat
REPEAT_RATE, 6, frames between subsequent repeats (1 <= REPEAT_RATE <= REPEAT_DELAY)

Ports:
frame_clk  in  1  vertical-sync frame clock; sole clock
Reset_n  in  1  asynchronous, active-low reset
keycode  in  8  current USB HID keycode; 0 = no key
wr_ack  in  1  grid store accepted the pending write
cell_row  out  3  cursor row, 0..GRID_N-1
cell_col  out  3  cursor column, 0..GRID_N-1
dir_down  out  1  entry direction: 0 = across, 1 = down
highlightX  out  10  X_ORIGIN + cell_col*CELL_SIZE
highlightY  out  10  Y_ORIGIN + cell_row*CELL_SIZE
wr_req  out  1  write request, held until acknowledged
wr_row  out  3  target row of the write
wr_col  out  3  target column of the write
wr_data  out  5  letter code: 1..26 = A..Z, 0 = blank

Behaviour:
- Reset (Reset_n=0, async): cell_row=0, cell_col=0, dir_down=0, wr_req=0, wr_row=0, wr_col=0, wr_data=0, prev_key=0, hold_cnt=0, state=IDLE. highlightX=4, highlightY=80. Reset mid-write drops wr_req immediately; the pending write is abandoned.
- Event generation:
  - prev_key is registered every edge.
  - New event when keycode != 0 and keycode != prev_key.
  - hold_cnt (8 bits) clears on a new event or when keycode = 0. It increments each frame while the same nonzero key is held.
  - Repeat event when hold_cnt == REPEAT_DELAY; hold_cnt then reloads to REPEAT_DELAY - REPEAT_RATE.
  - At most one event per frame.
- Key map:
  - 0x4F right, 0x50 left, 0x51 down, 0x52 up
  - 0x04..0x1D letters A..Z, mapped to wr_data = keycode - 3
  - 0x2A backspace
  - 0x2C space, toggles dir_down
  - All other codes are ignored and do not alter state.
- Every register update happens on the frame_clk edge that samples the event. Outputs reflect it from that edge on, so the latency is 1 edge.
- FSM states: IDLE, WRITE, BACKSPACE_WRITE.
  - IDLE, arrow event: move one cell. Clamp at the grid edge with no wrap. A move at an edge is a no-op.
  - IDLE, space event: toggle dir_down; the cursor does not move.
  - IDLE, letter event:
    - Set wr_req=1, wr_row/wr_col = cursor, wr_data = letter; go to WRITE.
    - In WRITE, on the edge where wr_ack=1: wr_req=0. Advance the cursor one cell, +col if across or +row if down, clamped at GRID_N-1. Return to IDLE.
  - IDLE, backspace event:
    - Set wr_req=1, wr_data=0 at the cursor; go to BACKSPACE_WRITE.
    - On wr_ack: wr_req=0, retreat one cell (-col or -row), clamped at 0. Return to IDLE.
  - While in WRITE or BACKSPACE_WRITE, all events are discarded, including repeats; hold_cnt still counts.
  - wr_ack sampled in IDLE is ignored.
- Simultaneous events: wr_ack together with a new event in the same cycle → the ack is processed and the event is discarded.
- Arithmetic: highlight pixel values are computed from the registered cell_row/cell_col. The products fit in 10 bits for the defaults; no overflow handling is required.

Decomposition:
- Package crossword_pkg holds:
  - GRID_N, CELL_SIZE, X_ORIGIN, Y_ORIGIN
  - keycode constants KEY_RIGHT/LEFT/DOWN/UP/BKSP/SPACE/A/Z
  - state_t enum {IDLE, WRITE, BACKSPACE_WRITE}
- Sub-module key_repeat holds prev_key, hold_cnt, and the new/repeat event logic. Its outputs are key_evt (1 bit) and evt_code (8 bits).
- cursor_controller contains the FSM, cursor registers and coordinate mapping.

Test Plan:
- Reset, then keycode 0x4F for 1 frame, then 0 → cell_col=1, highlightX=84. Five more presses → cell_col clamps at 4, highlightX=324.
- Hold 0x51 for 45 frames from row 0 → events at frames 0, 30, 36, 42 → cell_row=4 by frame 42, clamped thereafter.
- At cursor (2,1) across: keycode 0x0B ('H'); ack 3 frames later → wr_req held 3 frames with wr_row=2, wr_col=1, wr_data=8. After ack, cell_col=2.
- Space, then letter at (0,4) down, then backspace with immediate acks:
  - After the letter: dir_down=1, write of (0,4), cell_row=1.
  - Backspace: writes 0 at (1,4), cell_row returns to 0.
- Arrow and letter keys pressed while wr_req is pending → no cursor change and no second request. Ack coincident with a new key → the key is discarded.
- Assert Reset_n=0 mid-WRITE → wr_req falls without waiting for a clock. All outputs return to reset values; a late wr_ack is ignored.
